alu_exec_unit: RTL

//   Parametrised execute-stage unit: decodes ALUop/func7/func3 and computes the result. Extends the RV32I ALU operation set
//   to the full base integer set plus iterative M-extension multiply/divide.

---
 rtl/alu_exec_unit.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle RV32I-style operations plus iterative radix-2 multiply and restoring divide.
// The iterative operations stall the pipeline (in_ready low) until their result pulses out on out_valid.
module alu_exec_unit #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    input  logic [2:0]      alu_op,
    input  logic [6:0]      func7,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic            busy
);
    localparam int              SHW       = $clog2(XLEN);
    localparam logic [SHW-1:0]  LAST_ITER = SHW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA,
        OP_MUL, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILL
    } op_t;

    state_t state_q, state_d;
    op_t    op, mop_q, mop_d;

    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic            negq_q, negq_d, negr_q, negr_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            zero_q, zero_d, ill_q, ill_d, valid_q, valid_d;

    logic            accept, is_mul, is_div, is_sdiv, div_zero, div_ovf, div_fast;
    logic            a_neg, b_neg, q_bit;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] fast_res, step_hi, step_lo, fin_res;
    logic [XLEN:0]   mul_sum, rem_sh, rem_diff;

    function automatic op_t decode_base(input logic [2:0] f3, input logic arith);
        op_t o;
        case (f3)
            3'b000:  o = OP_ADD;
            3'b111:  o = OP_AND;
            3'b110:  o = OP_OR;
            3'b100:  o = OP_XOR;
            3'b010:  o = OP_SLT;
            3'b011:  o = OP_SLTU;
            3'b001:  o = OP_SLL;
            3'b101:  o = arith ? OP_SRA : OP_SRL;
            default: o = OP_ILL;
        endcase
        return o;
    endfunction

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        op = OP_ILL;
        case (alu_op)
            3'b000:         op = OP_ADD;
            3'b010, 3'b110: op = OP_SUB;
            3'b001:         op = decode_base(func3, func7[5]);
            3'b100: begin
                case (func7)
                    7'b0000000: op = decode_base(func3, 1'b0);
                    7'b0100000: begin
                        if (func3 == 3'b000)      op = OP_SUB;
                        else if (func3 == 3'b101) op = OP_SRA;
                    end
                    7'b0000001: begin
                        if (ENABLE_M) begin
                            case (func3)
                                3'b000:  op = OP_MUL;
                                3'b011:  op = OP_MULHU;
                                3'b100:  op = OP_DIV;
                                3'b101:  op = OP_DIVU;
                                3'b110:  op = OP_REM;
                                3'b111:  op = OP_REMU;
                                default: op = OP_ILL;
                            endcase
                        end
                    end
                    default: op = OP_ILL;
                endcase
            end
            default: op = OP_ILL;
        endcase
    end

    always_comb begin
        shamt    = src_b[SHW-1:0];
        a_neg    = src_a[XLEN-1];
        b_neg    = src_b[XLEN-1];
        is_mul   = (op == OP_MUL) || (op == OP_MULHU);
        is_div   = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        is_sdiv  = (op == OP_DIV) || (op == OP_REM);
        div_zero = (src_b == '0);
        div_ovf  = is_sdiv && (src_a == MIN_NEG) && (src_b == '1);
        div_fast = is_div && (div_zero || div_ovf);
        fast_res = '0;
        case (op)
            OP_ADD:           fast_res = src_a + src_b;
            OP_SUB:           fast_res = src_a - src_b;
            OP_AND:           fast_res = src_a & src_b;
            OP_OR:            fast_res = src_a | src_b;
            OP_XOR:           fast_res = src_a ^ src_b;
            OP_SLT:           fast_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            OP_SLTU:          fast_res = {{(XLEN-1){1'b0}}, src_a < src_b};
            OP_SLL:           fast_res = src_a << shamt;
            OP_SRL:           fast_res = src_a >> shamt;
            OP_SRA:           fast_res = $signed(src_a) >>> shamt;
            // Short-circuit divides: divide-by-zero or signed overflow, never iterated.
            OP_DIV, OP_DIVU:  fast_res = div_zero ? '1 : src_a;
            OP_REM, OP_REMU:  fast_res = div_zero ? src_a : '0;
            default:          fast_res = '0;
        endcase
    end

    // One iteration: shift-add on {hi,lo} for multiply, restoring subtract for divide.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh   = {hi_q, lo_q[XLEN-1]};
        rem_diff = rem_sh - {1'b0, opnd_q};
        q_bit    = ~rem_diff[XLEN];
        if (state_q == S_MUL) begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end else begin
            step_hi = q_bit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], q_bit};
        end
        case (mop_q)
            OP_MUL:          fin_res = step_lo;
            OP_MULHU:        fin_res = step_hi;
            OP_DIV, OP_DIVU: fin_res = negq_q ? -step_lo : step_lo;
            default:         fin_res = negr_q ? -step_hi : step_hi;
        endcase
    end

    assign accept = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && is_mul)                    state_d = S_MUL;
                else if (accept && is_div && !div_fast)  state_d = S_DIV;
            end
            default: if (flush || cnt_q == LAST_ITER) state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == S_IDLE);
        busy     = !in_ready;
    end

    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        mop_d   = mop_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        res_d   = res_q;
        zero_d  = zero_q;
        ill_d   = ill_q;
        valid_d = 1'b0;
        if (state_q == S_IDLE) begin
            if (accept) begin
                mop_d = op;
                cnt_d = '0;
                hi_d  = '0;
                if (is_mul) begin
                    lo_d   = src_b;
                    opnd_d = src_a;
                    negq_d = 1'b0;
                    negr_d = 1'b0;
                end else if (is_div && !div_fast) begin
                    lo_d   = (is_sdiv && a_neg) ? -src_a : src_a;
                    opnd_d = (is_sdiv && b_neg) ? -src_b : src_b;
                    negq_d = is_sdiv && (a_neg ^ b_neg);
                    negr_d = is_sdiv && a_neg;
                end else begin
                    valid_d = 1'b1;
                    res_d   = fast_res;
                    zero_d  = (fast_res == '0);
                    ill_d   = (op == OP_ILL);
                end
            end
        end else if (flush) begin
            cnt_d = '0;
        end else begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q + SHW'(1);
            if (cnt_q == LAST_ITER) begin
                valid_d = 1'b1;
                res_d   = fin_res;
                zero_d  = (fin_res == '0);
                ill_d   = 1'b0;
                cnt_d   = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            valid_q <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b1;
            ill_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ill_q   <= ill_d;
        end
    end

    // NOTE: working operands are loaded on every accept before use, so they carry no reset.
    always_ff @(posedge clk) begin
        hi_q   <= hi_d;
        lo_q   <= lo_d;
        opnd_q <= opnd_d;
        mop_q  <= mop_d;
        negq_q <= negq_d;
        negr_q <= negr_d;
    end

    assign out_valid = valid_q;
    assign result    = res_q;
    assign zero      = zero_q;
    assign illegal   = ill_q;
endmodule
